// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-set stream in, instruction-memory write port out
interface instr_encoder_loader_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [3:0]        in_sel;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [20:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;
  modport master (
    output in_valid, in_kind, in_sel, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  in_valid, in_kind, in_sel, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes decoded field sets into RV32I words and streams them into IMEM
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  instr_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 full,
  output logic                 err_illegal,
  output logic [15:0]          word_count
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE_S, FULL_S} state_t;
  state_t state, state_n;
  logic stage_v, last_seen, stage_n, last_n;
  logic acc, wr, legal, alu_ok, f7b, imm12_ok, br_ok;
  logic [2:0] f3;
  logic [20:0] imm;
  logic [31:0] wdata, enc;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] accepted, acc_n;
  assign imm = bus.in_imm;
  always_comb begin
    {alu_ok, f3, f7b} = 5'b0;
    case (bus.in_sel)
      4'b0010: {alu_ok, f3, f7b} = {1'b1, 3'b000, 1'b0};
      4'b0110: {alu_ok, f3, f7b} = {1'b1, 3'b000, 1'b1};
      4'b0011: {alu_ok, f3, f7b} = {1'b1, 3'b001, 1'b0};
      4'b0111: {alu_ok, f3, f7b} = {1'b1, 3'b010, 1'b0};
      4'b1000: {alu_ok, f3, f7b} = {1'b1, 3'b011, 1'b0};
      4'b0100: {alu_ok, f3, f7b} = {1'b1, 3'b100, 1'b0};
      4'b0101: {alu_ok, f3, f7b} = {1'b1, 3'b101, 1'b0};
      4'b0001: {alu_ok, f3, f7b} = {1'b1, 3'b110, 1'b0};
      4'b0000: {alu_ok, f3, f7b} = {1'b1, 3'b111, 1'b0};
      default: ;
    endcase
  end
  // immediates must sign-extend cleanly from their encoded width
  assign imm12_ok = &imm[20:11] || ~|imm[20:11];
  assign br_ok    = (&imm[20:12] || ~|imm[20:12]) && !imm[0] && bus.in_sel[2:1] != 2'b01;
  always_comb begin
    legal = 1'b0;
    enc   = 32'h0;
    case (bus.in_kind)
      3'd0: begin legal = alu_ok; enc = {1'b0, f7b, 5'b0, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011}; end
      3'd1: begin legal = imm12_ok && bus.in_sel == 4'b0010; enc = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011}; end
      3'd2: begin legal = imm12_ok; enc = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011}; end
      3'd3: begin legal = imm12_ok; enc = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011}; end
      3'd4: begin legal = br_ok; enc = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_sel[2:0], imm[4:1], imm[11], 7'b1100011}; end
      3'd5: begin legal = !imm[0]; enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111}; end
      default: ;
    endcase
  end
  assign wr           = stage_v && bus.imem_ready;
  assign bus.in_ready = state == RUN && (!stage_v || wr) && accepted < CW'(DEPTH) && !last_seen;
  assign acc          = bus.in_valid && bus.in_ready;
  assign stage_n      = (acc && legal) || (stage_v && !wr);
  assign last_n       = last_seen || (acc && bus.in_last);
  assign acc_n        = accepted + CW'(acc && legal);
  assign bus.imem_we    = stage_v;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // session ends only once the stage has drained; in_last takes priority over DEPTH
  always_comb
    state_n = (state != RUN) ? (start ? RUN : state)
            : stage_n ? RUN
            : last_n ? DONE_S
            : (acc_n == CW'(DEPTH)) ? FULL_S : RUN;
  always_comb begin
    busy = state == RUN;
    done = state == DONE_S;
    full = state == FULL_S;
  end
  always_ff @(posedge clk) begin
    if (reset || (start && state != RUN)) begin
      stage_v     <= 1'b0;
      last_seen   <= 1'b0;
      accepted    <= '0;
      addr        <= ADDR_W'(BASE_ADDR);
      word_count  <= 16'd0;
      err_illegal <= 1'b0;
      if (reset) wdata <= 32'h0;
    end else begin
      stage_v   <= stage_n;
      last_seen <= last_n;
      accepted  <= acc_n;
      if (acc && legal) wdata <= enc;
      if (acc && !legal) err_illegal <= 1'b1;
      if (wr) begin
        addr       <= addr + ADDR_W'(4);
        word_count <= word_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven encoding checks plus stall, full, illegal and reset sequences
module tb_instr_encoder_loader;
  localparam logic [31:0] BASE = 32'h100;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset, start;
  logic busy, done, full, err_illegal;
  logic [15:0] word_count;
  instr_encoder_loader_if #(.ADDR_W(32)) bus();
  instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done),
    .full(full), .err_illegal(err_illegal), .word_count(word_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] kind; logic [3:0] sel; logic [4:0] rd, rs1, rs2;
    logic [20:0] imm; logic last; logic legal; logic [31:0] wdata;
  } vec_t;
  vec_t v[14];
  vec_t x;
  logic [63:0] expq[$];
  logic [63:0] e_m;
  logic [31:0] exp_addr;
  int tests = 0, fails = 0, sess_cnt = 0, sess_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.imem_we && bus.imem_ready) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got addr %h data %h required no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        e_m = expq.pop_front();
        check("wr_addr", bus.imem_addr, e_m[63:32]);
        check("wr_data", bus.imem_wdata, e_m[31:0]);
      end
    end
  task automatic start_s();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = BASE; sess_cnt = 0; sess_err = 0;
  endtask
  task automatic drive(input vec_t t);
    bus.in_kind = t.kind; bus.in_sel = t.sel; bus.in_rd = t.rd; bus.in_rs1 = t.rs1;
    bus.in_rs2 = t.rs2; bus.in_imm = t.imm; bus.in_last = t.last; bus.in_valid = 1'b1;
  endtask
  task automatic send(input vec_t t);
    bit ok = 0;
    drive(t);
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: got in_ready 0 required 1 within 40 cycles");
    end else begin
      if (t.legal) begin expq.push_back({exp_addr, t.wdata}); exp_addr += 4; sess_cnt++; end
      else sess_err = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_end(input logic exp_done, input logic exp_full);
    bit ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (done || full) ok = 1;
    end
    check("end_done", 32'(done), 32'(exp_done));
    check("end_full", 32'(full), 32'(exp_full));
    check("end_busy", 32'(busy), 32'd0);
    check("end_count", 32'(word_count), 32'(sess_cnt));
    check("end_err", 32'(err_illegal), 32'(sess_err));
    check("end_in_ready", 32'(bus.in_ready), 32'd0);
    check("end_queue_empty", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    #300000;
    fails++;
    $display("FAIL global_timeout: got no finish required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.imem_ready = 1'b1;
    bus.in_kind = 3'd0; bus.in_sel = 4'd0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0;
    bus.in_rs2 = 5'd0; bus.in_imm = 21'd0; bus.in_last = 1'b0;
    v[0]  = '{3'd0, 4'b0010, 5'd3,  5'd1,  5'd2,  21'd0,       1'b0, 1'b1, 32'h002081B3};
    v[1]  = '{3'd0, 4'b0110, 5'd3,  5'd1,  5'd2,  21'd0,       1'b0, 1'b1, 32'h402081B3};
    v[2]  = '{3'd1, 4'b0010, 5'd1,  5'd0,  5'd0,  21'd5,       1'b0, 1'b1, 32'h00500093};
    v[3]  = '{3'd2, 4'b0000, 5'd5,  5'd2,  5'd0,  21'd8,       1'b1, 1'b1, 32'h00812283};
    v[4]  = '{3'd3, 4'b0000, 5'd0,  5'd2,  5'd5,  21'd8,       1'b0, 1'b1, 32'h00512423};
    v[5]  = '{3'd4, 4'b0000, 5'd0,  5'd1,  5'd2,  21'h1FFFFC,  1'b0, 1'b1, 32'hFE208EE3};
    v[6]  = '{3'd5, 4'b0000, 5'd1,  5'd0,  5'd0,  21'd8,       1'b1, 1'b1, 32'h008000EF};
    v[7]  = '{3'd6, 4'b0000, 5'd1,  5'd1,  5'd1,  21'd0,       1'b0, 1'b0, 32'h0};
    v[8]  = '{3'd1, 4'b0010, 5'd1,  5'd1,  5'd0,  21'd2048,    1'b0, 1'b0, 32'h0};
    v[9]  = '{3'd0, 4'b1001, 5'd1,  5'd1,  5'd1,  21'd0,       1'b0, 1'b0, 32'h0};
    v[10] = '{3'd4, 4'b0010, 5'd0,  5'd1,  5'd2,  21'd8,       1'b0, 1'b0, 32'h0};
    v[11] = '{3'd5, 4'b0000, 5'd1,  5'd0,  5'd0,  21'd3,       1'b0, 1'b0, 32'h0};
    v[12] = '{3'd1, 4'b0010, 5'd2,  5'd2,  5'd0,  21'h1FFFFF,  1'b0, 1'b1, 32'hFFF10113};
    v[13] = '{3'd0, 4'b0111, 5'd10, 5'd11, 5'd12, 21'd0,       1'b1, 1'b1, 32'h00C5A533};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_addr", bus.imem_addr, BASE);
    @(posedge clk); #1;
    // three sessions from the table; the first ends on in_last exactly at DEPTH
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || v[i-1].last) start_s();
      send(v[i]);
      if (v[i].last) wait_end(1'b1, 1'b0);
    end
    // illegal set carrying in_last with an empty stage
    start_s();
    x = v[7]; x.kind = 3'd7; x.last = 1'b1;
    send(x);
    check("ill_last_done", 32'(done), 32'd1);
    check("ill_last_count", 32'(word_count), 32'd0);
    check("ill_last_err", 32'(err_illegal), 32'd1);
    check("ill_last_we", 32'(bus.imem_we), 32'd0);
    @(posedge clk); #1;
    // memory stall for three cycles with the next set waiting
    start_s();
    bus.imem_ready = 1'b0;
    send(v[0]);
    x = v[1]; x.last = 1'b1;
    drive(x);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_we", 32'(bus.imem_we), 32'd1);
      check("stall_addr", bus.imem_addr, BASE);
      check("stall_data", bus.imem_wdata, 32'h002081B3);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.imem_ready = 1'b1;
    send(x);
    wait_end(1'b1, 1'b0);
    // DEPTH sets fill the session, further offers are refused
    start_s();
    for (int k = 0; k < 4; k++) begin
      x = v[k]; x.last = 1'b0;
      send(x);
    end
    for (int k = 0; k < 2; k++) begin
      drive(v[4 + k]);
      repeat (3) begin
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_end(1'b0, 1'b1);
    start_s();
    x = v[8]; x.last = 1'b1;
    send(x);
    check("imm2048_err", 32'(err_illegal), 32'd1);
    check("imm2048_done", 32'(done), 32'd1);
    check("imm2048_count", 32'(word_count), 32'd0);
    check("imm2048_we", 32'(bus.imem_we), 32'd0);
    @(posedge clk); #1;
    // reset while a word is stalled in the stage
    start_s();
    send(v[0]);
    send(v[1]);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_we", 32'(bus.imem_we), 32'd1);
    check("pre_rst_count", 32'(word_count), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    expq.delete();
    check("mid_rst_we", 32'(bus.imem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(word_count), 32'd0);
    check("mid_rst_addr", bus.imem_addr, BASE);
    reset = 1'b0;
    bus.imem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_we", 32'(bus.imem_we), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
